// File: rtl/iq_mixer_decimator.sv
`default_nettype none
// ============================================================================
// iq_mixer_decimator : ADC x NCO I/Q mixer with integrate-and-dump decimation
// Optional build macro IQ_MIXER_DECIMATOR_ROUND_EN : round-half-up + saturate
// Revision: 1.0
// ============================================================================
module iq_mixer_decimator #(
  parameter int DECIM = 256,
  parameter int OUT_W = 24
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    tick_i,
  input  logic                    en_i,
  input  logic                    clr_i,
  input  logic signed [15:0]      adc_i,
  input  logic signed [15:0]      lo_sin_i,
  input  logic signed [15:0]      lo_cos_i,
  output logic signed [OUT_W-1:0] i_o,
  output logic signed [OUT_W-1:0] q_o,
  output logic                    valid_o,
  input  logic                    ready_i,
  output logic                    overrun_o,
  output logic                    busy_o
);

  localparam int CNT_W = $clog2(DECIM);
  localparam int ACC_W = 32 + CNT_W;
  localparam int SHIFT = ACC_W - OUT_W;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DECIM - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                    state_q, state_d;
  logic signed [31:0]        p_i_q, p_i_d, p_q_q, p_q_d;
  logic                      pv_q, pv_d;
  logic signed [ACC_W-1:0]   acc_i_q, acc_i_d, acc_q_q, acc_q_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic signed [OUT_W-1:0]   i_q, i_d, q_q, q_d;
  logic                      valid_q, valid_d;
  logic                      overrun_q, overrun_d;

  logic signed [31:0]        prod_i, prod_q;
  logic signed [ACC_W-1:0]   sum_i, sum_q;
  logic signed [OUT_W-1:0]   res_i, res_q;
  logic                      run_ok;

  assign prod_i = adc_i * lo_sin_i;
  assign prod_q = adc_i * lo_cos_i;
  assign sum_i  = acc_i_q + {{CNT_W{p_i_q[31]}}, p_i_q};
  assign sum_q  = acc_q_q + {{CNT_W{p_q_q[31]}}, p_q_q};

`ifdef IQ_MIXER_DECIMATOR_ROUND_EN
  localparam logic [ACC_W:0] RND = (ACC_W + 1)'(1) << (SHIFT - 1);

  // Rounding only ever adds, so the only possible overflow is positive.
  function automatic logic [OUT_W-1:0] round_sat(input logic [ACC_W-1:0] s);
    logic [ACC_W:0] r;
    r = {s[ACC_W-1], s} + RND;
    if (!r[ACC_W] && r[ACC_W-1]) begin
      return {1'b0, {(OUT_W-1){1'b1}}};
    end
    return r[ACC_W-1 -: OUT_W];
  endfunction

  assign res_i = round_sat(sum_i);
  assign res_q = round_sat(sum_q);
`else
  assign res_i = sum_i[ACC_W-1 -: OUT_W];
  assign res_q = sum_q[ACC_W-1 -: OUT_W];

  if (SHIFT > 0) begin : g_trunc_lsb
    logic lsb_unused;
    assign lsb_unused = ^{sum_i[SHIFT-1:0], sum_q[SHIFT-1:0]};
  end
`endif

  assign run_ok = (state_q == ST_RUN) && en_i;

  always_comb begin
    state_d   = state_q;
    p_i_d     = p_i_q;
    p_q_d     = p_q_q;
    pv_d      = pv_q;
    acc_i_d   = acc_i_q;
    acc_q_d   = acc_q_q;
    cnt_d     = cnt_q;
    i_d       = i_q;
    q_d       = q_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;

    case (state_q)
      ST_IDLE: if (en_i)  state_d = ST_RUN;
      ST_RUN:  if (!en_i) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (valid_q && ready_i) valid_d = 1'b0;

    if (clr_i) begin
      acc_i_d   = '0;
      acc_q_d   = '0;
      cnt_d     = '0;
      pv_d      = 1'b0;
      overrun_d = 1'b0;
    end else if (!run_ok) begin
      // Idle or aborting: the partial block is dropped, output buffer kept.
      acc_i_d = '0;
      acc_q_d = '0;
      cnt_d   = '0;
      pv_d    = 1'b0;
    end else begin
      pv_d = tick_i;
      if (tick_i) begin
        p_i_d = prod_i;
        p_q_d = prod_q;
      end
      if (pv_q) begin
        if (cnt_q == CNT_LAST) begin
          i_d     = res_i;
          q_d     = res_q;
          valid_d = 1'b1;
          if (valid_q && !ready_i) overrun_d = 1'b1;
          acc_i_d = '0;
          acc_q_d = '0;
          cnt_d   = '0;
        end else begin
          acc_i_d = sum_i;
          acc_q_d = sum_q;
          cnt_d   = cnt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      p_i_q     <= '0;
      p_q_q     <= '0;
      pv_q      <= 1'b0;
      acc_i_q   <= '0;
      acc_q_q   <= '0;
      cnt_q     <= '0;
      i_q       <= '0;
      q_q       <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      p_i_q     <= p_i_d;
      p_q_q     <= p_q_d;
      pv_q      <= pv_d;
      acc_i_q   <= acc_i_d;
      acc_q_q   <= acc_q_d;
      cnt_q     <= cnt_d;
      i_q       <= i_d;
      q_q       <= q_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign i_o       = i_q;
  assign q_o       = q_q;
  assign valid_o   = valid_q;
  assign overrun_o = overrun_q;
  assign busy_o    = (state_q == ST_RUN);

endmodule
`default_nettype wire

// File: tb/tb_iq_mixer_decimator.sv
`default_nettype none
// ============================================================================
// tb_iq_mixer_decimator : directed scoreboard bench, DECIM=4 / OUT_W=24
// Revision: 1.0
// ============================================================================
module tb_iq_mixer_decimator;

  localparam int DECIM = 4;
  localparam int OUT_W = 24;

  logic                    clk = 1'b0;
  logic                    rst_ni = 1'b0;
  logic                    tick_i = 1'b0;
  logic                    en_i = 1'b0;
  logic                    clr_i = 1'b0;
  logic signed [15:0]      adc_i = '0;
  logic signed [15:0]      lo_sin_i = '0;
  logic signed [15:0]      lo_cos_i = '0;
  logic                    ready_i = 1'b0;
  logic signed [OUT_W-1:0] i_o, q_o;
  logic                    valid_o, overrun_o, busy_o;

  int total = 0;
  int bad   = 0;
  logic signed [OUT_W-1:0] exp_i_q[$];
  logic signed [OUT_W-1:0] exp_q_q[$];

  iq_mixer_decimator #(.DECIM(DECIM), .OUT_W(OUT_W)) dut (
    .clk_i    (clk),
    .rst_ni   (rst_ni),
    .tick_i   (tick_i),
    .en_i     (en_i),
    .clr_i    (clr_i),
    .adc_i    (adc_i),
    .lo_sin_i (lo_sin_i),
    .lo_cos_i (lo_cos_i),
    .i_o      (i_o),
    .q_o      (q_o),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .overrun_o(overrun_o),
    .busy_o   (busy_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic feed(input int n, input logic signed [15:0] a,
                      input logic signed [15:0] s, input logic signed [15:0] c);
    for (int k = 0; k < n; k++) begin
      tick_i = 1'b1; adc_i = a; lo_sin_i = s; lo_cos_i = c;
      step();
    end
    tick_i = 1'b0;
  endtask

  task automatic push_exp(input logic signed [OUT_W-1:0] ei,
                          input logic signed [OUT_W-1:0] eq);
    exp_i_q.push_back(ei);
    exp_q_q.push_back(eq);
  endtask

  task automatic pop_check(input string tag);
    logic signed [OUT_W-1:0] ei, eq;
    if (exp_i_q.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s observed=output expected=queued_entry", tag);
    end else begin
      ei = exp_i_q.pop_front();
      eq = exp_q_q.pop_front();
      check({tag, "_i"}, i_o, ei);
      check({tag, "_q"}, q_o, eq);
    end
  endtask

  task automatic consume(input string tag);
    ready_i = 1'b1;
    step();
    ready_i = 1'b0;
    check({tag, "_valid_after_read"}, valid_o, 0);
  endtask

  initial begin
    // Reset
    step(); step();
    check("rst_i", i_o, 0);
    check("rst_q", q_o, 0);
    check("rst_valid", valid_o, 0);
    check("rst_overrun", overrun_o, 0);
    check("rst_busy", busy_o, 0);
    rst_ni = 1'b1;
    en_i = 1'b1;
    step();
    check("busy_run", busy_o, 1);

    // T1 basic with exact latency
    push_exp(24'sd1048576, 24'sd0);
    feed(4, 16'sd16384, 16'sd16384, 16'sd0);
    check("t1_valid_early", valid_o, 0);
    step();
    check("t1_valid", valid_o, 1);
    pop_check("t1");
    consume("t1");

    // T2 sign / full scale
    push_exp(24'sd4194304, -24'sd2097152);
    feed(4, -16'sd32768, -16'sd32768, 16'sd16384);
    step();
    check("t2_valid", valid_o, 1);
    pop_check("t2");
    consume("t2");

    // T3 backpressure across two blocks, then clear
    push_exp(24'sd1048576, 24'sd0);
    feed(4, 16'sd16384, 16'sd16384, 16'sd0);
    step();
    pop_check("t3a");
    check("t3a_overrun", overrun_o, 0);
    push_exp(24'sd4194304, -24'sd2097152);
    feed(4, -16'sd32768, -16'sd32768, 16'sd16384);
    step();
    check("t3b_valid", valid_o, 1);
    check("t3b_overrun", overrun_o, 1);
    pop_check("t3b");
    clr_i = 1'b1;
    step();
    clr_i = 1'b0;
    check("t3_clr_overrun", overrun_o, 0);
    check("t3_clr_i_held", i_o, 24'sd4194304);
    check("t3_clr_valid_held", valid_o, 1);
    check("t3_clr_busy", busy_o, 1);
    consume("t3");

    // T4 dump coinciding with a read
    push_exp(24'sd1048576, 24'sd0);
    feed(4, 16'sd16384, 16'sd16384, 16'sd0);
    step();
    pop_check("t4a");
    push_exp(-24'sd1048576, -24'sd1048576);
    feed(4, -16'sd16384, 16'sd16384, 16'sd16384);
    ready_i = 1'b1;
    step();
    ready_i = 1'b0;
    check("t4_valid", valid_o, 1);
    check("t4_overrun", overrun_o, 0);
    pop_check("t4b");
    consume("t4");

    // T5 abort mid-block, then fresh block
    feed(2, 16'sd16384, 16'sd16384, 16'sd0);
    en_i = 1'b0;
    step();
    check("t5_busy_idle", busy_o, 0);
    feed(2, 16'sd16384, 16'sd16384, 16'sd0);
    en_i = 1'b1;
    step();
    check("t5_busy_run", busy_o, 1);
    push_exp(24'sd1048576, 24'sd0);
    feed(4, 16'sd16384, 16'sd16384, 16'sd0);
    step();
    check("t5_valid", valid_o, 1);
    pop_check("t5");

    // Reset mid-block with a pending result and overrun set
    push_exp(24'sd4194304, -24'sd2097152);
    feed(4, -16'sd32768, -16'sd32768, 16'sd16384);
    step();
    pop_check("t5b");
    check("t5b_overrun", overrun_o, 1);
    feed(2, 16'sd16384, 16'sd16384, 16'sd0);
    rst_ni = 1'b0;
    step();
    rst_ni = 1'b1;
    check("t5_rst_i", i_o, 0);
    check("t5_rst_q", q_o, 0);
    check("t5_rst_valid", valid_o, 0);
    check("t5_rst_overrun", overrun_o, 0);
    check("t5_rst_busy", busy_o, 0);

    // T6 rounding boundary: sum of 512 sits exactly at half an output LSB
    step();
`ifdef IQ_MIXER_DECIMATOR_ROUND_EN
    push_exp(24'sd1, 24'sd0);
`else
    push_exp(24'sd0, 24'sd0);
`endif
    feed(4, 16'sd128, 16'sd1, 16'sd0);
    step();
    check("t6_valid", valid_o, 1);
    pop_check("t6");
    consume("t6");

    check("sb_empty", exp_i_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
